// File: rtl/serial_pkg.sv
// Shared definitions for the serial receiver and its matching sender:
// frame constants, receiver FSM states and the even-parity helper.
package serial_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 5;
  localparam logic START_BIT          = 1'b0;
  localparam logic STOP_BIT           = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_e;

  // Even parity holds when data plus parity bit carry an even number of ones.
  function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
    return ~(^{data, par});
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period counter 0..CLKS_PER_BIT-1 with synchronous clear, a mid-bit
// sample strobe and an end-of-bit wrap strobe.
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic sample,
  output logic wrap
);

  localparam logic [9:0] LAST = 10'(CLKS_PER_BIT - 1);
  localparam logic [9:0] MID  = 10'((CLKS_PER_BIT - 1) / 2);

  logic [9:0] count_q;
  logic [9:0] count_d;

  assign sample = (count_q == MID);
  assign wrap   = (count_q == LAST);

  // Next count: held at zero while cleared, otherwise count and wrap.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 10'd0;
    end else if (wrap) begin
      count_d = 10'd0;
    end else begin
      count_d = count_q + 10'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 10'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_receiver.sv
// UART-style receiver: 1 start, 8 data LSB first, optional even parity, 1 stop.
// Define SERIAL_RX_PARITY_EN to expect the parity bit after D7.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic [7:0] rx_data,
  output logic       rx_status,
  output logic       frame_error,
  output logic       parity_error
);

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);
`ifdef SERIAL_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = PARITY;
`else
  localparam rx_state_e AFTER_DATA = STOP;
`endif

  rx_state_e            state_q, state_d;
  logic                 sync1_q, din_s_q, din_prev_q;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_status_q, rx_status_d;
  logic                 frame_error_q, frame_error_d;
  logic                 timer_clear_s, sample_s, wrap_s;
`ifdef SERIAL_RX_PARITY_EN
  logic                 parity_bad_q, parity_bad_d;
  logic                 parity_error_q, parity_error_d;
`endif

  // Timer idles at zero so the first count after a start edge is 0.
  assign timer_clear_s = (state_q == IDLE) || (state_q == WAIT_IDLE);

  serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear_s),
    .sample (sample_s),
    .wrap   (wrap_s)
  );

  // Next-state and output-pulse logic for the frame FSM.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_idx_d     = bit_idx_q;
    rx_data_d     = rx_data_q;
    rx_status_d   = 1'b0;
    frame_error_d = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    parity_bad_d   = parity_bad_q;
    parity_error_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (din_prev_q && !din_s_q) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (sample_s && (din_s_q != START_BIT)) begin
          state_d = IDLE;
        end else if (wrap_s) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (sample_s) begin
          shift_d = {din_s_q, shift_q[DATA_BITS-1:1]};
        end else begin
          shift_d = shift_q;
        end
        if (wrap_s) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_IDX) begin
            state_d = AFTER_DATA;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
`ifdef SERIAL_RX_PARITY_EN
        if (sample_s) begin
          parity_bad_d = ~even_parity_ok(shift_q, din_s_q);
        end else begin
          parity_bad_d = parity_bad_q;
        end
        if (wrap_s) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        // A bad stop bit wins over a parity mismatch so pulses stay exclusive.
        if (sample_s && (din_s_q == STOP_BIT)) begin
          state_d = IDLE;
`ifdef SERIAL_RX_PARITY_EN
          if (parity_bad_q) begin
            parity_error_d = 1'b1;
          end else begin
            rx_data_d   = shift_q;
            rx_status_d = 1'b1;
          end
`else
          rx_data_d   = shift_q;
          rx_status_d = 1'b1;
`endif
        end else if (sample_s) begin
          frame_error_d = 1'b1;
          state_d       = WAIT_IDLE;
        end else begin
          state_d = STOP;
        end
      end
      WAIT_IDLE: begin
        if (din_s_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b1;
      din_s_q       <= 1'b1;
      din_prev_q    <= 1'b1;
      shift_q       <= '0;
      bit_idx_q     <= 3'd0;
      rx_data_q     <= 8'h00;
      rx_status_q   <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_bad_q   <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      sync1_q       <= din;
      din_s_q       <= sync1_q;
      din_prev_q    <= din_s_q;
      shift_q       <= shift_d;
      bit_idx_q     <= bit_idx_d;
      rx_data_q     <= rx_data_d;
      rx_status_q   <= rx_status_d;
      frame_error_q <= frame_error_d;
`ifdef SERIAL_RX_PARITY_EN
      parity_bad_q   <= parity_bad_d;
      parity_error_q <= parity_error_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_status   = rx_status_q;
  assign frame_error = frame_error_q;
`ifdef SERIAL_RX_PARITY_EN
  assign parity_error = parity_error_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5, clk cycles per serial bit; legal range 3..1023.
REQ-002 Ports SHALL be, clock and reset first:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  1  asynchronous serial line; idle high.
- rx_data  output  8  last correctly received byte.
- rx_status  output  1  one-cycle pulse: rx_data just updated.
- frame_error  output  1  one-cycle pulse: stop bit sampled low.
- parity_error  output  1  one-cycle pulse: parity mismatch (see Configuration).

Function
REQ-003 Frame format SHALL be: start bit 0, 8 data bits LSB first, optional parity bit, stop bit 1.
REQ-004 din SHALL pass a 2-flop synchronizer; all logic uses the synchronized value din_s.
REQ-005 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-006 IDLE: a din_s 1->0 transition SHALL enter START and clear the bit-timer.
REQ-007 The bit-timer SHALL count 0..CLKS_PER_BIT-1 and wrap; sampling SHALL occur at count (CLKS_PER_BIT-1)/2, integer division.
REQ-008 START: if the sample is 1, the FSM SHALL return to IDLE (false start) with no output pulse; if 0, it SHALL go to DATA after the timer wraps.
REQ-009 DATA: 8 samples SHALL shift into a byte register LSB first; a 3-bit counter SHALL track the index; after index 7 wraps, go to PARITY (macro on) or STOP.
REQ-010 STOP, sample 1: rx_data <= shifted byte and rx_status = 1 for exactly one cycle, the cycle after the sample; FSM then returns to IDLE immediately.
REQ-011 STOP, sample 0: frame_error pulses one cycle; rx_data SHALL NOT change; FSM goes to WAIT_IDLE.
REQ-012 WAIT_IDLE SHALL stay until din_s = 1, then go to IDLE (no retrigger on a held-low break).
REQ-013 On a parity mismatch, rx_status SHALL NOT assert and rx_data SHALL NOT change, even when the stop bit is good.
REQ-014 rx_status, frame_error and parity_error SHALL be mutually exclusive in any cycle.
REQ-015 A new start edge SHALL be accepted on the first clk after returning to IDLE (back-to-back frames supported).
REQ-016 Latency: rx_status asserts 1 clk after the mid-stop-bit sample.

Reset
REQ-017 reset SHALL force FSM = IDLE, timer = 0, bit index = 0, rx_data = 8'h00, all pulse outputs = 0, and synchronizer flops = 1.
REQ-018 reset asserted mid-frame SHALL abandon the frame with no pulse output; after release, reception restarts only on a fresh falling edge.

Configuration
REQ-019 Macro SERIAL_RX_PARITY_EN defined: the PARITY state is used and one even-parity bit is expected after D7; a mismatch pulses parity_error in the cycle after the stop sample, and the FSM proceeds through STOP normally.
REQ-020 Macro undefined: the PARITY state is unreachable and parity_error is tied 0; frame = 10 bits.

Structure
REQ-021 Package serial_pkg SHALL hold: the FSM state enum, DATA_BITS = 8, default CLKS_PER_BIT, START_BIT = 0 and STOP_BIT = 1 constants; the matching sender shares it.
REQ-022 Sub-module serial_bit_timer SHALL provide the counter with clear, sample strobe and wrap strobe; synchronizer is inline.

Verification
REQ-023 Benches SHALL cover, with CLKS_PER_BIT = 5:
- Frame 8'b1100_0101 -> rx_data = 8'hC5, one rx_status pulse 1 clk after the stop mid-sample, no errors.
- Back-to-back frames 8'hC5 then 8'h27, no idle gap -> two rx_status pulses, rx_data = 8'h27 at the end.
- 1-clk low glitch on idle din -> START then IDLE, no pulse outputs, rx_data unchanged.
- Frame 8'hA5 with stop bit 0, then din held low 30 clk -> single frame_error pulse, rx_data unchanged, no retrigger until din returns high.
- reset asserted during DATA bit 4 -> all outputs 0; a following 8'h3C frame is received correctly.
- SERIAL_RX_PARITY_EN defined, frame 8'h01 with parity bit 0 -> parity_error pulse, no rx_status; with parity bit 1 -> rx_data = 8'h01.
